mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port arbiter and sequencer in front of the shared `memory` block.
- Serves three requesters:
  - the instruction-fetch path of the processor FSM,
  - the load datapath,
  - the debug/VGA memory viewer.
- Replaces the processor's hard-coded wait_count/wait_time delays with a req/ack handshake and a fixed, parameterised memory latency.
- The FSM advances on ack instead of counting cycles.

Parameters:
- MEM_LATENCY, 2: cycles between driving mem_addr/mem_op and valid mem_data_out; legal range 1..15.
- DBG_STARVE_MAX, 8: consecutive grants to other ports while dbg_req is high before dbg is forced to top priority; legal range 1..255.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  asynchronous reset, active low
- if_req  in  1  instruction fetch request, level
- if_addr  in  32  fetch address, stable while if_req high
- if_ack  out  1  one-cycle pulse, fetch complete
- if_rdata  out  32  fetched word, valid when if_ack high and held until next grant to if
- d_req  in  1  data request, level
- d_addr  in  32  data address
- d_op  in  8  memory op code (LOAD_BYTE=1, LOAD_HALF=2, LOAD_WORD=3, LOAD_BYTE_U=4, LOAD_HALF_U=5)
- d_ack  out  1  one-cycle pulse, data access complete
- d_rdata  out  32  load result, valid with d_ack
- d_err  out  1  high with d_ack when d_op is not in 1..5
- dbg_req  in  1  debug read request
- dbg_addr  in  32  debug word address
- dbg_ack  out  1  one-cycle pulse
- dbg_rdata  out  32  debug read data
- mem_addr  out  32  to memory
- mem_op  out  8  to memory; 0 means no access
- mem_data_out  in  32  from memory
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst low): state=IDLE; mem_addr=0, mem_op=0; all acks=0, d_err=0; all rdata=0; starve counter=0; busy=0. Reset mid-transaction aborts it; no ack is issued.
- States:
  - IDLE: arbitrate. If any req is high, latch the grant, address and op, then go to ISSUE.
  - ISSUE: drive mem_addr/mem_op for the granted port. if and dbg use op 3. d uses d_op. Load the latency counter with MEM_LATENCY-1. Go to WAIT.
  - WAIT: hold mem_addr/mem_op. Decrement the counter. At 0, capture mem_data_out into the granted port's rdata register and go to DONE.
  - DONE: pulse the granted port's ack for exactly 1 cycle; mem_op=0; go to IDLE.
- Latency: req sampled high in IDLE at edge N gives ack high in cycle N+2+MEM_LATENCY. No back-to-back issue; minimum spacing between grants is 3+MEM_LATENCY cycles.
- Priority:
  - Normal order is d > if > dbg.
  - If the starve counter is at or above DBG_STARVE_MAX and dbg_req is high, dbg wins.
  - Starve counter: increments on each grant to if or d while dbg_req is high; clears on a dbg grant or when dbg_req is low in IDLE; saturates at 255.
- Handshake rules:
  - Requester holds req, addr and op stable until it sees its ack.
  - Requester drops req by the edge following ack; a req still high in IDLE is treated as a new request.
  - A req deasserted mid-transaction does not abort: the access completes and ack still pulses; the requester ignores it.
  - Changing addr or op after the grant has no effect; values are latched in IDLE.
- Invalid d_op (0 or >5):
  - No memory access: skip ISSUE/WAIT and go IDLE→DONE.
  - d_ack=1, d_err=1, d_rdata=0.
- rdata registers change only on capture for their own port.
- Simultaneous requests are resolved only in IDLE; requests arriving during WAIT are queued implicitly by level.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN
- With it defined:
  - Adds outputs stat_if, stat_d, stat_dbg (16 bits each).
  - Each counts completed acks for its port, saturates at 16'hFFFF, and resets to 0.
  - Adds input stat_clr (1): synchronous clear of all three counters; clear wins over a same-cycle increment.
- Without it: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan (all at MEM_LATENCY=2):
- Single fetch: if_req=1 with if_addr=0x10, memory word 0x00500093 → if_ack at cycle 4 after the sampling edge, if_rdata=0x00500093, mem_op=3 during ISSUE/WAIT, busy=0 afterwards.
- Contention: if_req, d_req and dbg_req all raised in the same cycle, d_op=3 → grant order d, if, dbg; each ack is 5 cycles apart from the previous one.
- Starvation: DBG_STARVE_MAX=2, dbg_req held, if_req and d_req re-asserted continuously → after 2 non-dbg grants the 3rd grant goes to dbg; the counter then clears.
- Bad op: d_op=7 → d_ack 1 cycle after the sampling edge, d_err=1, d_rdata=0, mem_op stays 0.
- Reset mid-operation: rst pulled low during WAIT of a fetch → no if_ack; mem_op=0 and state=IDLE immediately; a new request after release completes normally.
- Stats (with MEM_ARBITER_STATS_EN): 3 fetches and 1 data access → stat_if=3, stat_d=1, stat_dbg=0; then stat_clr → all 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the three requester ports and the memory-side port of mem_arbiter.
// The stats counters and their clear input exist only when MEM_ARBITER_STATS_EN is defined.
// The slave modport is the arbiter's view; the master modport is the requesters'/memory view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic [31:0] d_addr;
    logic [7:0]  d_op;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    logic [31:0] mem_addr;
    logic [7:0]  mem_op;
    logic [31:0] mem_data_out;

    logic        busy;

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] stat_if;
    logic [15:0] stat_d;
    logic [15:0] stat_dbg;
    logic        stat_clr;
`endif

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_op, dbg_req, dbg_addr, mem_data_out,
        output if_ack, if_rdata, d_ack, d_rdata, d_err, dbg_ack, dbg_rdata,
        output mem_addr, mem_op, busy
`ifdef MEM_ARBITER_STATS_EN
        , input stat_clr
        , output stat_if, stat_d, stat_dbg
`endif
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, d_op, dbg_req, dbg_addr, mem_data_out,
        input  if_ack, if_rdata, d_ack, d_rdata, d_err, dbg_ack, dbg_rdata,
        input  mem_addr, mem_op, busy
`ifdef MEM_ARBITER_STATS_EN
        , output stat_clr
        , input stat_if, stat_d, stat_dbg
`endif
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port arbiter/sequencer for the shared memory: d > if > dbg, with dbg anti-starvation.
// Latency: ack pulses MEM_LATENCY+2 cycles after the request is sampled in IDLE (1 cycle for a bad d_op).
// Backpressure: requests are levels; anything raised while busy waits until the FSM returns to IDLE.
// Optional feature macro: MEM_ARBITER_STATS_EN (per-port completed-ack counters with clear).
module mem_arbiter #(
    parameter int MEM_LATENCY    = 2,
    parameter int DBG_STARVE_MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {GNT_IF, GNT_D, GNT_DBG} gnt_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
    localparam logic [7:0] STARVE_LIM = 8'(DBG_STARVE_MAX);

    state_t      state;
    gnt_t        gnt;
    gnt_t        pick;
    logic        any_req;
    logic        d_op_ok;
    logic        bad_op;
    logic [3:0]  lat_cnt;
    logic [7:0]  starve;
    logic [31:0] pick_addr;

    // Winner selection as seen in IDLE: a starved dbg beats everything, else d > if > dbg.
    always_comb begin
        pick      = GNT_IF;
        pick_addr = bus.if_addr;
        any_req   = bus.if_req | bus.d_req | bus.dbg_req;
        d_op_ok   = (bus.d_op >= 8'd1) && (bus.d_op <= 8'd5);
        if (bus.dbg_req && (starve >= STARVE_LIM)) begin
            pick      = GNT_DBG;
            pick_addr = bus.dbg_addr;
        end else if (bus.d_req) begin
            pick      = GNT_D;
            pick_addr = bus.d_addr;
        end else if (bus.if_req) begin
            pick      = GNT_IF;
            pick_addr = bus.if_addr;
        end else if (bus.dbg_req) begin
            pick      = GNT_DBG;
            pick_addr = bus.dbg_addr;
        end
    end

    // Sequencer: grant in IDLE, present the access, count out the latency, then pulse the ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            gnt           <= GNT_IF;
            bad_op        <= 1'b0;
            lat_cnt       <= 4'd0;
            starve        <= 8'd0;
            bus.mem_addr  <= 32'd0;
            bus.mem_op    <= 8'd0;
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.dbg_ack   <= 1'b0;
            bus.d_err     <= 1'b0;
            bus.if_rdata  <= 32'd0;
            bus.d_rdata   <= 32'd0;
            bus.dbg_rdata <= 32'd0;
            bus.busy      <= 1'b0;
        end else begin
            bus.if_ack  <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.dbg_ack <= 1'b0;
            bus.d_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.dbg_req) starve <= 8'd0;
                    if (any_req) begin
                        gnt      <= pick;
                        bus.busy <= 1'b1;
                        if (pick == GNT_DBG)
                            starve <= 8'd0;
                        else if (bus.dbg_req && starve != 8'hFF)
                            starve <= starve + 8'd1;
                        // A bad op never touches memory; it is answered straight from DONE.
                        if (pick == GNT_D && !d_op_ok) begin
                            bad_op <= 1'b1;
                            state  <= DONE;
                        end else begin
                            bus.mem_addr <= pick_addr;
                            bus.mem_op   <= (pick == GNT_D) ? bus.d_op : 8'd3;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        case (gnt)
                            GNT_D:   bus.d_rdata   <= bus.mem_data_out;
                            GNT_DBG: bus.dbg_rdata <= bus.mem_data_out;
                            default: bus.if_rdata  <= bus.mem_data_out;
                        endcase
                        bus.mem_op <= 8'd0;
                        state      <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: begin
                    case (gnt)
                        GNT_D:   bus.d_ack   <= 1'b1;
                        GNT_DBG: bus.dbg_ack <= 1'b1;
                        default: bus.if_ack  <= 1'b1;
                    endcase
                    if (bad_op) begin
                        bus.d_err   <= 1'b1;
                        bus.d_rdata <= 32'd0;
                    end
                    bad_op   <= 1'b0;
                    bus.mem_op <= 8'd0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    // Saturating completed-ack counters; a clear takes precedence over a same-cycle ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.stat_if  <= 16'd0;
            bus.stat_d   <= 16'd0;
            bus.stat_dbg <= 16'd0;
        end else if (bus.stat_clr) begin
            bus.stat_if  <= 16'd0;
            bus.stat_d   <= 16'd0;
            bus.stat_dbg <= 16'd0;
        end else begin
            if (bus.if_ack && bus.stat_if != 16'hFFFF)   bus.stat_if  <= bus.stat_if + 16'd1;
            if (bus.d_ack && bus.stat_d != 16'hFFFF)     bus.stat_d   <= bus.stat_d + 16'd1;
            if (bus.dbg_ack && bus.stat_dbg != 16'hFFFF) bus.stat_dbg <= bus.stat_dbg + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at MEM_LATENCY=2, DBG_STARVE_MAX=2.
// Memory model: address 0x10 holds 0x00500093, every other address returns {addr[15:0], 8'h00, op}.
// Latencies are counted in rising edges after the edge that samples the request.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.MEM_LATENCY(2), .DBG_STARVE_MAX(2)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Combinational memory stand-in
    always_comb begin
        if (bus.mem_op == 8'd0)
            bus.mem_data_out = 32'hBAD0BAD0;
        else if (bus.mem_addr == 32'h10)
            bus.mem_data_out = 32'h00500093;
        else
            bus.mem_data_out = {bus.mem_addr[15:0], 8'h00, bus.mem_op};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.if_req   = 1'b0; bus.if_addr  = 32'd0;
        bus.d_req    = 1'b0; bus.d_addr   = 32'd0; bus.d_op = 8'd0;
        bus.dbg_req  = 1'b0; bus.dbg_addr = 32'd0;
`ifdef MEM_ARBITER_STATS_EN
        bus.stat_clr = 1'b0;
`endif
    endtask

    // Issue one request on port (0=if,1=d,2=dbg), wait for its ack, then drop the request.
    task automatic run_req(input int port, input logic [31:0] addr, input logic [7:0] op,
                           output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = 32'd0;
        case (port)
            1:       begin bus.d_req = 1'b1; bus.d_addr = addr; bus.d_op = op; end
            2:       begin bus.dbg_req = 1'b1; bus.dbg_addr = addr; end
            default: begin bus.if_req = 1'b1; bus.if_addr = addr; end
        endcase
        for (int i = 0; i < 30; i++) begin
            tick();
            if (port == 0 && bus.if_ack)  begin lat = i; rd = bus.if_rdata;  break; end
            if (port == 1 && bus.d_ack)   begin lat = i; rd = bus.d_rdata;   break; end
            if (port == 2 && bus.dbg_ack) begin lat = i; rd = bus.dbg_rdata; break; end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.dbg_req = 1'b0;
        checks++; if (lat < 0) $display("FAIL run_req_timeout: port %0d got no ack within 30 cycles", port); else passed++;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.mem_op !== 8'd0) $display("FAIL reset_mem_op: got %h want 00", bus.mem_op); else passed++;
        checks++; if (bus.mem_addr !== 32'd0) $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); else passed++;
        checks++; if ({bus.if_ack, bus.d_ack, bus.dbg_ack, bus.d_err} !== 4'b0) $display("FAIL reset_acks: got %b want 0000", {bus.if_ack, bus.d_ack, bus.dbg_ack, bus.d_err}); else passed++;
        checks++; if ((bus.if_rdata | bus.d_rdata | bus.dbg_rdata) !== 32'd0) $display("FAIL reset_rdata: got %h want 0", bus.if_rdata | bus.d_rdata | bus.dbg_rdata); else passed++;
`ifdef MEM_ARBITER_STATS_EN
        checks++; if ({bus.stat_if, bus.stat_d, bus.stat_dbg} !== 48'd0) $display("FAIL reset_stats: got %h want 0", {bus.stat_if, bus.stat_d, bus.stat_dbg}); else passed++;
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_idle_after_release: busy %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_single_fetch;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        tick();   // sampling edge: now ISSUE
        checks++; if (bus.mem_op !== 8'd3) $display("FAIL fetch_op_issue: got %h want 03", bus.mem_op); else passed++;
        checks++; if (bus.mem_addr !== 32'h10) $display("FAIL fetch_addr_issue: got %h want 10", bus.mem_addr); else passed++;
        checks++; if (bus.busy !== 1'b1) $display("FAIL fetch_busy: got %b want 1", bus.busy); else passed++;
        tick();   // WAIT
        checks++; if (bus.mem_op !== 8'd3) $display("FAIL fetch_op_wait: got %h want 03", bus.mem_op); else passed++;
        tick();
        tick();   // DONE
        checks++; if (bus.if_ack !== 1'b0) $display("FAIL fetch_ack_early: got %b want 0", bus.if_ack); else passed++;
        tick();   // 4 edges after sampling
        checks++; if (bus.if_ack !== 1'b1) $display("FAIL fetch_ack_cycle4: got %b want 1", bus.if_ack); else passed++;
        checks++; if (bus.if_rdata !== 32'h00500093) $display("FAIL fetch_rdata: got %h want 00500093", bus.if_rdata); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL fetch_busy_after: got %b want 0", bus.busy); else passed++;
        bus.if_req = 1'b0;
        tick();
        checks++; if (bus.if_ack !== 1'b0) $display("FAIL fetch_ack_pulse_width: got %b want 0", bus.if_ack); else passed++;
        checks++; if (bus.if_rdata !== 32'h00500093) $display("FAIL fetch_rdata_held: got %h want 00500093", bus.if_rdata); else passed++;
    endtask

    task automatic test_contention;
        int t_d = -1, t_if = -1, t_dbg = -1;
        logic [31:0] r_d = 0, r_if = 0, r_dbg = 0;
        bus.d_req = 1'b1;   bus.d_addr = 32'h20;  bus.d_op = 8'd3;
        bus.if_req = 1'b1;  bus.if_addr = 32'h40;
        bus.dbg_req = 1'b1; bus.dbg_addr = 32'h30;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.d_ack)   begin t_d = i;   r_d = bus.d_rdata;     bus.d_req = 1'b0;   end
            if (bus.if_ack)  begin t_if = i;  r_if = bus.if_rdata;   bus.if_req = 1'b0;  end
            if (bus.dbg_ack) begin t_dbg = i; r_dbg = bus.dbg_rdata; bus.dbg_req = 1'b0; end
        end
        checks++; if (t_d != 4) $display("FAIL contention_d_time: got %0d want 4", t_d); else passed++;
        checks++; if (t_if != 9) $display("FAIL contention_if_time: got %0d want 9", t_if); else passed++;
        checks++; if (t_dbg != 14) $display("FAIL contention_dbg_time: got %0d want 14", t_dbg); else passed++;
        checks++; if (r_d !== 32'h00200003) $display("FAIL contention_d_rdata: got %h want 00200003", r_d); else passed++;
        checks++; if (r_if !== 32'h00400003) $display("FAIL contention_if_rdata: got %h want 00400003", r_if); else passed++;
        checks++; if (r_dbg !== 32'h00300003) $display("FAIL contention_dbg_rdata: got %h want 00300003", r_dbg); else passed++;
    endtask

    task automatic test_starvation;
        int order [4] = '{-1, -1, -1, -1};
        int n = 0;
        logic [7:0] st_d2 = 8'hEE, st_dbg = 8'hEE;
        logic [31:0] r_dbg = 0;
        bus.d_req = 1'b1;   bus.d_addr = 32'h24;  bus.d_op = 8'd3;
        bus.if_req = 1'b1;  bus.if_addr = 32'h44;
        bus.dbg_req = 1'b1; bus.dbg_addr = 32'h34;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick();
            if (bus.if_ack)  begin order[n] = 0; n++; end
            if (bus.d_ack)   begin order[n] = 1; if (n == 1) st_d2 = dut.starve; n++; end
            if (bus.dbg_ack) begin order[n] = 2; st_dbg = dut.starve; r_dbg = bus.dbg_rdata; n++; end
        end
        idle_inputs();
        tick();
        tick();
        checks++; if (order[0] != 1) $display("FAIL starve_grant1: got %0d want 1(d)", order[0]); else passed++;
        checks++; if (order[1] != 1) $display("FAIL starve_grant2: got %0d want 1(d)", order[1]); else passed++;
        checks++; if (order[2] != 2) $display("FAIL starve_grant3: got %0d want 2(dbg)", order[2]); else passed++;
        checks++; if (order[3] != 1) $display("FAIL starve_grant4: got %0d want 1(d)", order[3]); else passed++;
        checks++; if (st_d2 !== 8'd2) $display("FAIL starve_count_before_dbg: got %0d want 2", st_d2); else passed++;
        checks++; if (st_dbg !== 8'd0) $display("FAIL starve_count_cleared: got %0d want 0", st_dbg); else passed++;
        checks++; if (r_dbg !== 32'h00340003) $display("FAIL starve_dbg_rdata: got %h want 00340003", r_dbg); else passed++;
    endtask

    task automatic test_bad_op;
        bus.d_req = 1'b1; bus.d_addr = 32'h28; bus.d_op = 8'd7;
        tick();   // sampling edge: straight to DONE
        checks++; if (bus.mem_op !== 8'd0) $display("FAIL badop_mem_op: got %h want 00", bus.mem_op); else passed++;
        checks++; if (bus.d_ack !== 1'b0) $display("FAIL badop_ack_early: got %b want 0", bus.d_ack); else passed++;
        tick();
        checks++; if (bus.d_ack !== 1'b1) $display("FAIL badop_ack_cycle1: got %b want 1", bus.d_ack); else passed++;
        checks++; if (bus.d_err !== 1'b1) $display("FAIL badop_err: got %b want 1", bus.d_err); else passed++;
        checks++; if (bus.d_rdata !== 32'd0) $display("FAIL badop_rdata: got %h want 0", bus.d_rdata); else passed++;
        checks++; if (bus.mem_op !== 8'd0) $display("FAIL badop_mem_op_done: got %h want 00", bus.mem_op); else passed++;
        checks++; if (bus.if_rdata !== 32'h00400003) $display("FAIL badop_if_rdata_untouched: got %h want 00400003", bus.if_rdata); else passed++;
        bus.d_req = 1'b0; bus.d_op = 8'd0;
        tick();
        checks++; if ({bus.d_ack, bus.d_err} !== 2'b00) $display("FAIL badop_pulse_width: got %b want 00", {bus.d_ack, bus.d_err}); else passed++;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        int lat;
        logic [31:0] rd;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        tick();   // ISSUE
        tick();   // WAIT
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_op !== 8'd0) $display("FAIL rstmid_mem_op: got %h want 00", bus.mem_op); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else passed++;
        bus.if_req = 1'b0;
        repeat (3) begin tick(); if (bus.if_ack) seen++; end
        rst_n = 1'b1;
        repeat (6) begin tick(); if (bus.if_ack) seen++; end
        checks++; if (seen != 0) $display("FAIL rstmid_no_ack: got %0d acks want 0", seen); else passed++;
        checks++; if (bus.if_rdata !== 32'd0) $display("FAIL rstmid_rdata_cleared: got %h want 0", bus.if_rdata); else passed++;
        run_req(0, 32'h50, 8'd0, lat, rd);
        checks++; if (lat != 4) $display("FAIL rstmid_recover_latency: got %0d want 4", lat); else passed++;
        checks++; if (rd !== 32'h00500003) $display("FAIL rstmid_recover_rdata: got %h want 00500003", rd); else passed++;
        tick();
    endtask

`ifdef MEM_ARBITER_STATS_EN
    task automatic test_stats;
        int lat;
        logic [31:0] rd;
        bus.stat_clr = 1'b1;
        tick();
        bus.stat_clr = 1'b0;
        checks++; if ({bus.stat_if, bus.stat_d, bus.stat_dbg} !== 48'd0) $display("FAIL stats_initial_clear: got %h want 0", {bus.stat_if, bus.stat_d, bus.stat_dbg}); else passed++;
        run_req(0, 32'h60, 8'd0, lat, rd);
        run_req(0, 32'h64, 8'd0, lat, rd);
        run_req(0, 32'h68, 8'd0, lat, rd);
        run_req(1, 32'h70, 8'd1, lat, rd);
        tick();
        checks++; if (bus.stat_if !== 16'd3) $display("FAIL stats_if: got %0d want 3", bus.stat_if); else passed++;
        checks++; if (bus.stat_d !== 16'd1) $display("FAIL stats_d: got %0d want 1", bus.stat_d); else passed++;
        checks++; if (bus.stat_dbg !== 16'd0) $display("FAIL stats_dbg: got %0d want 0", bus.stat_dbg); else passed++;
        bus.stat_clr = 1'b1;
        tick();
        bus.stat_clr = 1'b0;
        checks++; if ({bus.stat_if, bus.stat_d, bus.stat_dbg} !== 48'd0) $display("FAIL stats_clear: got %h want 0", {bus.stat_if, bus.stat_d, bus.stat_dbg}); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_bad_op();
        test_reset_mid();
`ifdef MEM_ARBITER_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
